// File: rtl/mem_txn_limiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_bus_t
// Purpose  : AXI-style memory bus bundle used between mem_arbiter, the
//            transaction limiter and the DDR controller.
//            'master' modport: the view of a link that faces its request
//            source (requests arrive, responses leave).
//            'slave' modport: the view of a link that faces its request
//            sink (requests leave, responses arrive).
// Revision : 1.0 - initial release
// ============================================================================
interface axi_bus_t #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int c_STRB_W = DATA_W / 8;

  // Write address channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [c_STRB_W-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // Write response channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // Read address channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  // Read data channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport slave (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface
`default_nettype wire

// File: rtl/mem_txn_limiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_txn_limiter
// Purpose  : Zero-latency outstanding-transaction limiter and drain controller
//            between mem_arbiter and the DDR controller. Caps in-flight reads
//            and writes, keeps W beats behind their AW, and offers a drain
//            handshake for quiescing the memory path.
// Options  : MEM_TXN_PERF_EN - enables the 32-bit saturating AR/AW stall
//            counters; without it perf_*_stall are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_txn_limiter #(
  parameter int MAX_RD = 16,
  parameter int MAX_WR = 16,
  parameter int CNT_W  = $clog2((MAX_RD > MAX_WR) ? (MAX_RD + 1) : (MAX_WR + 1))
) (
  input  logic             clk,
  input  logic             rstn,
  axi_bus_t.master         up,
  axi_bus_t.slave          dn,
  input  logic             drain_req,
  output logic             drained,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic             err_underflow,
  output logic [31:0]      perf_rd_stall,
  output logic [31:0]      perf_wr_stall
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_MAX_RD = CNT_W'(MAX_RD);
  localparam logic [CNT_W-1:0] c_MAX_WR = CNT_W'(MAX_WR);
  localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO   = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] w_credit_q, w_credit_d;
  logic             drained_q, drained_d;
  logic             err_underflow_q, err_underflow_d;

  logic w_run;
  logic w_ar_ok;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_last_hs;
  logic w_r_last_hs;
  logic w_b_hs;
  logic w_all_idle;

  // ---------------------------------------------------------------------------
  // Payload and response-side handshakes pass straight through
  // ---------------------------------------------------------------------------
  assign dn.awid    = up.awid;
  assign dn.awaddr  = up.awaddr;
  assign dn.awlen   = up.awlen;
  assign dn.awsize  = up.awsize;
  assign dn.awburst = up.awburst;
  assign dn.wdata   = up.wdata;
  assign dn.wstrb   = up.wstrb;
  assign dn.wlast   = up.wlast;
  assign dn.arid    = up.arid;
  assign dn.araddr  = up.araddr;
  assign dn.arlen   = up.arlen;
  assign dn.arsize  = up.arsize;
  assign dn.arburst = up.arburst;
  assign up.bid     = dn.bid;
  assign up.bresp   = dn.bresp;
  assign up.bvalid  = dn.bvalid;
  assign dn.bready  = up.bready;
  assign up.rid     = dn.rid;
  assign up.rdata   = dn.rdata;
  assign up.rresp   = dn.rresp;
  assign up.rlast   = dn.rlast;
  assign up.rvalid  = dn.rvalid;
  assign dn.rready  = up.rready;

  // ---------------------------------------------------------------------------
  // Request gating; W waits for credit earned by an earlier AW handshake
  // ---------------------------------------------------------------------------
  assign w_run   = (state_q == ST_RUN);
  assign w_ar_ok = w_run && (rd_cnt_q < c_MAX_RD);
  assign w_aw_ok = w_run && (wr_cnt_q < c_MAX_WR) && (w_credit_q < c_MAX_WR);
  assign w_w_ok  = (w_credit_q != c_ZERO);

  assign dn.arvalid = up.arvalid & w_ar_ok;
  assign up.arready = dn.arready & w_ar_ok;
  assign dn.awvalid = up.awvalid & w_aw_ok;
  assign up.awready = dn.awready & w_aw_ok;
  assign dn.wvalid  = up.wvalid  & w_w_ok;
  assign up.wready  = dn.wready  & w_w_ok;

  assign w_ar_hs     = dn.arvalid & dn.arready;
  assign w_aw_hs     = dn.awvalid & dn.awready;
  assign w_w_last_hs = dn.wvalid  & dn.wready & dn.wlast;
  assign w_r_last_hs = dn.rvalid  & dn.rready & dn.rlast;
  assign w_b_hs      = dn.bvalid  & dn.bready;
  assign w_all_idle  = (rd_cnt_q == c_ZERO) && (wr_cnt_q == c_ZERO) && (w_credit_q == c_ZERO);

  // Outstanding counters: simultaneous +1/-1 cancel; a lone decrement at zero
  // holds the count and flags a protocol underflow
  always_comb begin
    rd_cnt_d        = rd_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    w_credit_d      = w_credit_q;
    err_underflow_d = err_underflow_q;

    if (w_ar_hs && !w_r_last_hs) begin
      rd_cnt_d = rd_cnt_q + c_ONE;
    end else if (!w_ar_hs && w_r_last_hs) begin
      if (rd_cnt_q == c_ZERO) begin
        err_underflow_d = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q - c_ONE;
      end
    end

    if (w_aw_hs && !w_b_hs) begin
      wr_cnt_d = wr_cnt_q + c_ONE;
    end else if (!w_aw_hs && w_b_hs) begin
      if (wr_cnt_q == c_ZERO) begin
        err_underflow_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q - c_ONE;
      end
    end

    // W handshakes need nonzero credit, so this decrement never sees zero
    if (w_aw_hs && !w_w_last_hs) begin
      w_credit_d = w_credit_q + c_ONE;
    end else if (!w_aw_hs && w_w_last_hs && (w_credit_q != c_ZERO)) begin
      w_credit_d = w_credit_q - c_ONE;
    end
  end

  // Drain state machine next-state; drained follows the state register
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)      state_d = ST_RUN;
        else if (w_all_idle) state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    drained_d = (state_d == ST_DRAINED);
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ST_RUN;
      rd_cnt_q        <= c_ZERO;
      wr_cnt_q        <= c_ZERO;
      w_credit_q      <= c_ZERO;
      drained_q       <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_cnt_q        <= rd_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      w_credit_q      <= w_credit_d;
      drained_q       <= drained_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign drained        = drained_q;
  assign rd_outstanding = rd_cnt_q;
  assign wr_outstanding = wr_cnt_q;
  assign err_underflow  = err_underflow_q;

`ifdef MEM_TXN_PERF_EN
  logic [31:0] perf_rd_stall_q, perf_rd_stall_d;
  logic [31:0] perf_wr_stall_q, perf_wr_stall_d;

  // Saturating stall counters: only limit-caused blocking in RUN counts
  always_comb begin
    perf_rd_stall_d = perf_rd_stall_q;
    perf_wr_stall_d = perf_wr_stall_q;
    if (up.arvalid && w_run && (rd_cnt_q == c_MAX_RD) && (perf_rd_stall_q != 32'hFFFF_FFFF)) begin
      perf_rd_stall_d = perf_rd_stall_q + 32'd1;
    end
    if (up.awvalid && w_run && ((wr_cnt_q == c_MAX_WR) || (w_credit_q == c_MAX_WR)) &&
        (perf_wr_stall_q != 32'hFFFF_FFFF)) begin
      perf_wr_stall_d = perf_wr_stall_q + 32'd1;
    end
  end

  // Stall counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_rd_stall_q <= 32'd0;
      perf_wr_stall_q <= 32'd0;
    end else begin
      perf_rd_stall_q <= perf_rd_stall_d;
      perf_wr_stall_q <= perf_wr_stall_d;
    end
  end

  assign perf_rd_stall = perf_rd_stall_q;
  assign perf_wr_stall = perf_wr_stall_q;
`else
  assign perf_rd_stall = 32'd0;
  assign perf_wr_stall = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_txn_limiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_txn_limiter
// Purpose  : Self-checking bench for mem_txn_limiter (MAX_RD = MAX_WR = 4).
//            Directed scenarios plus a randomized run against an
//            integer-arithmetic reference of the limiter rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_txn_limiter;
  localparam int MAX_RD = 4;
  localparam int MAX_WR = 4;
  localparam int CW     = $clog2(5);
`ifdef MEM_TXN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          drain_req = 1'b0;
  logic          drained;
  logic [CW-1:0] rd_outstanding;
  logic [CW-1:0] wr_outstanding;
  logic          err_underflow;
  logic [31:0]   perf_rd_stall;
  logic [31:0]   perf_wr_stall;

  int checks = 0;
  int failures = 0;

  axi_bus_t u_up ();
  axi_bus_t u_dn ();

  always #5 clk = ~clk;

  mem_txn_limiter #(.MAX_RD(MAX_RD), .MAX_WR(MAX_WR), .CNT_W(CW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .up            (u_up),
    .dn            (u_dn),
    .drain_req     (drain_req),
    .drained       (drained),
    .rd_outstanding(rd_outstanding),
    .wr_outstanding(wr_outstanding),
    .err_underflow (err_underflow),
    .perf_rd_stall (perf_rd_stall),
    .perf_wr_stall (perf_wr_stall)
  );

  // ---------------------------------------------------------------------------
  // Reference: integer bookkeeping of the limiter rules, driven only by the
  // stimulus this bench applies. mode 0=running, 1=draining, 2=drained.
  // ---------------------------------------------------------------------------
  int          m_rd = 0, m_wr = 0, m_wc = 0, m_mode = 0;
  int          m_rd_n, m_wr_n, m_wc_n;
  logic        m_uf = 1'b0;
  logic [31:0] m_prs = 0, m_pws = 0;
  logic        m_ar_ok, m_aw_ok, m_w_ok, m_ar_hs, m_aw_hs, m_w_dec, m_r_dec, m_b_dec;

  assign m_ar_ok = (m_mode == 0) && (m_rd < MAX_RD);
  assign m_aw_ok = (m_mode == 0) && (m_wr < MAX_WR) && (m_wc < MAX_WR);
  assign m_w_ok  = (m_wc != 0);
  assign m_ar_hs = u_up.arvalid && u_dn.arready && m_ar_ok;
  assign m_aw_hs = u_up.awvalid && u_dn.awready && m_aw_ok;
  assign m_w_dec = u_up.wvalid && u_dn.wready && u_up.wlast && m_w_ok;
  assign m_r_dec = u_dn.rvalid && u_up.rready && u_dn.rlast;
  assign m_b_dec = u_dn.bvalid && u_up.bready;
  assign m_rd_n  = m_rd + int'(m_ar_hs) - int'(m_r_dec);
  assign m_wr_n  = m_wr + int'(m_aw_hs) - int'(m_b_dec);
  assign m_wc_n  = m_wc + int'(m_aw_hs) - int'(m_w_dec);

  always @(posedge clk) begin
    if (!rstn) begin
      m_rd <= 0; m_wr <= 0; m_wc <= 0; m_mode <= 0;
      m_uf <= 1'b0; m_prs <= 0; m_pws <= 0;
    end else begin
      m_rd <= (m_rd_n < 0) ? 0 : m_rd_n;
      m_wr <= (m_wr_n < 0) ? 0 : m_wr_n;
      m_wc <= (m_wc_n < 0) ? 0 : m_wc_n;
      m_uf <= m_uf | (m_rd_n < 0) | (m_wr_n < 0);
      if (m_mode == 0 && drain_req) m_mode <= 1;
      else if (m_mode == 1 && !drain_req) m_mode <= 0;
      else if (m_mode == 1 && m_rd == 0 && m_wr == 0 && m_wc == 0) m_mode <= 2;
      else if (m_mode == 2 && !drain_req) m_mode <= 0;
      if (PERF && u_up.arvalid && m_mode == 0 && m_rd == MAX_RD && m_prs != 32'hFFFF_FFFF)
        m_prs <= m_prs + 32'd1;
      if (PERF && u_up.awvalid && m_mode == 0 && (m_wr == MAX_WR || m_wc == MAX_WR) &&
          m_pws != 32'hFFFF_FFFF)
        m_pws <= m_pws + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_up.awid = '0; u_up.awaddr = '0; u_up.awlen = '0; u_up.awsize = 3'd3; u_up.awburst = 2'd1;
    u_up.awvalid = 1'b0; u_up.wdata = '0; u_up.wstrb = '1; u_up.wlast = 1'b0; u_up.wvalid = 1'b0;
    u_up.bready = 1'b1; u_up.arid = '0; u_up.araddr = '0; u_up.arlen = '0; u_up.arsize = 3'd3;
    u_up.arburst = 2'd1; u_up.arvalid = 1'b0; u_up.rready = 1'b1;
    u_dn.awready = 1'b1; u_dn.wready = 1'b1; u_dn.arready = 1'b1;
    u_dn.bid = '0; u_dn.bresp = '0; u_dn.bvalid = 1'b0;
    u_dn.rid = '0; u_dn.rdata = '0; u_dn.rresp = '0; u_dn.rlast = 1'b0; u_dn.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    #1;
    checks++;
    if ({rd_outstanding, wr_outstanding} !== '0) begin
      failures++; $display("FAIL reset_counts got rd=%0d wr=%0d exp 0/0", rd_outstanding, wr_outstanding);
    end
    checks++;
    if ({drained, err_underflow} !== 2'b00) begin
      failures++; $display("FAIL reset_flags got drained=%b uf=%b exp 0/0", drained, err_underflow);
    end
    checks++;
    if ({perf_rd_stall, perf_wr_stall} !== 64'd0) begin
      failures++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_rd_stall, perf_wr_stall);
    end
    checks++;
    if ({u_up.arready, u_up.awready, u_up.wready} !== 3'b110) begin
      failures++; $display("FAIL reset_ready got %b exp 110", {u_up.arready, u_up.awready, u_up.wready});
    end
    tick();
  endtask

  task automatic test_read_limit();
    int hs = 0;
    u_up.rready = 1'b0;
    u_up.arvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (u_dn.arvalid && u_dn.arready) hs++;
      tick();
    end
    #1;
    checks++;
    if (hs !== 4) begin failures++; $display("FAIL rl_hs_count got %0d exp 4", hs); end
    checks++;
    if (rd_outstanding !== 3'd4 || u_up.arready !== 1'b0) begin
      failures++; $display("FAIL rl_full got rd=%0d arready=%b exp 4/0", rd_outstanding, u_up.arready);
    end
    u_dn.rvalid = 1'b1; u_dn.rlast = 1'b1; u_up.rready = 1'b1;
    tick();
    u_dn.rvalid = 1'b0;
    #1;
    checks++;
    if (rd_outstanding !== 3'd3 || u_up.arready !== 1'b1) begin
      failures++; $display("FAIL rl_reopen got rd=%0d arready=%b exp 3/1", rd_outstanding, u_up.arready);
    end
    tick();
    u_up.arvalid = 1'b0;
    #1;
    checks++;
    if (rd_outstanding !== 3'd4) begin failures++; $display("FAIL rl_fifth got rd=%0d exp 4", rd_outstanding); end
    u_dn.rvalid = 1'b1;
    repeat (4) tick();
    u_dn.rvalid = 1'b0; u_dn.rlast = 1'b0;
    #1;
    checks++;
    if (rd_outstanding !== 3'd0) begin failures++; $display("FAIL rl_empty got rd=%0d exp 0", rd_outstanding); end
    tick();
  endtask

  task automatic test_write_order();
    u_up.wvalid = 1'b1; u_up.wlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({u_dn.wvalid, u_up.wready} !== 2'b00) begin
        failures++; $display("FAIL wo_w_early cyc=%0d got %b exp 00", i, {u_dn.wvalid, u_up.wready});
      end
      tick();
    end
    u_up.awvalid = 1'b1; u_up.awlen = 8'd3;
    #1;
    checks++;
    if ({u_dn.awvalid, u_up.awready, u_dn.wvalid, u_up.wready} !== 4'b1100) begin
      failures++; $display("FAIL wo_aw_cycle got %b exp 1100", {u_dn.awvalid, u_up.awready, u_dn.wvalid, u_up.wready});
    end
    tick();
    u_up.awvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      u_up.wlast = (b == 3);
      #1;
      checks++;
      if ({u_dn.wvalid, u_up.wready} !== 2'b11) begin
        failures++; $display("FAIL wo_beat beat=%0d got %b exp 11", b, {u_dn.wvalid, u_up.wready});
      end
      tick();
    end
    #1;
    checks++;
    if ({u_dn.wvalid, u_up.wready, wr_outstanding} !== {2'b00, 3'd1}) begin
      failures++; $display("FAIL wo_after_burst got w=%b wr=%0d exp 00/1", {u_dn.wvalid, u_up.wready}, wr_outstanding);
    end
    u_up.wvalid = 1'b0; u_up.wlast = 1'b0;
    u_dn.bvalid = 1'b1; u_up.bready = 1'b1;
    tick();
    u_dn.bvalid = 1'b0;
    #1;
    checks++;
    if (wr_outstanding !== 3'd0) begin failures++; $display("FAIL wo_b_done got wr=%0d exp 0", wr_outstanding); end
    tick();
  endtask

  task automatic test_simultaneous();
    u_up.arvalid = 1'b1;
    repeat (2) tick();
    u_dn.rvalid = 1'b1; u_dn.rlast = 1'b1; u_up.rready = 1'b1;
    tick();
    u_up.arvalid = 1'b0; u_dn.rvalid = 1'b0;
    #1;
    checks++;
    if (rd_outstanding !== 3'd2) begin failures++; $display("FAIL sim_rd_hold got rd=%0d exp 2", rd_outstanding); end
    u_dn.rvalid = 1'b1;
    repeat (2) tick();
    u_dn.rvalid = 1'b0; u_dn.rlast = 1'b0;
    u_up.awvalid = 1'b1;
    repeat (2) tick();
    u_dn.bvalid = 1'b1; u_up.bready = 1'b1;
    tick();
    u_up.awvalid = 1'b0; u_dn.bvalid = 1'b0;
    #1;
    checks++;
    if (wr_outstanding !== 3'd2) begin failures++; $display("FAIL sim_wr_hold got wr=%0d exp 2", wr_outstanding); end
    u_up.wvalid = 1'b1; u_up.wlast = 1'b1; u_dn.bvalid = 1'b1;
    repeat (2) tick();
    u_dn.bvalid = 1'b0;
    tick();
    #1;
    checks++;
    if ({wr_outstanding, u_up.wready} !== {3'd0, 1'b0}) begin
      failures++; $display("FAIL sim_clean got wr=%0d wready=%b exp 0/0", wr_outstanding, u_up.wready);
    end
    u_up.wvalid = 1'b0; u_up.wlast = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    u_up.arvalid = 1'b1;
    repeat (3) tick();
    u_up.arvalid = 1'b0;
    drain_req = 1'b1;
    tick();
    u_up.arvalid = 1'b1;
    #1;
    checks++;
    if ({u_dn.arvalid, u_up.arready, drained} !== 3'b000) begin
      failures++; $display("FAIL dr_block got %b exp 000", {u_dn.arvalid, u_up.arready, drained});
    end
    u_dn.rvalid = 1'b1; u_dn.rlast = 1'b1; u_up.rready = 1'b1;
    repeat (3) tick();
    u_dn.rvalid = 1'b0;
    #1;
    checks++;
    if ({rd_outstanding, drained} !== {3'd0, 1'b0}) begin
      failures++; $display("FAIL dr_not_yet got rd=%0d drained=%b exp 0/0", rd_outstanding, drained);
    end
    tick();
    #1;
    checks++;
    if (drained !== 1'b1) begin failures++; $display("FAIL dr_rise got drained=%b exp 1", drained); end
    drain_req = 1'b0;
    #1;
    checks++;
    if (u_up.arready !== 1'b0) begin failures++; $display("FAIL dr_still_blocked got arready=%b exp 0", u_up.arready); end
    tick();
    #1;
    checks++;
    if ({u_up.arready, drained} !== 2'b10) begin
      failures++; $display("FAIL dr_resume got arready/drained=%b exp 10", {u_up.arready, drained});
    end
    tick();
    u_up.arvalid = 1'b0;
    #1;
    checks++;
    if (rd_outstanding !== 3'd1) begin failures++; $display("FAIL dr_resume_cnt got rd=%0d exp 1", rd_outstanding); end
    u_dn.rvalid = 1'b1;
    tick();
    u_dn.rvalid = 1'b0; u_dn.rlast = 1'b0;
    drain_req = 1'b1;
    tick();
    #1;
    checks++;
    if (drained !== 1'b0) begin failures++; $display("FAIL dr_idle_step1 got drained=%b exp 0", drained); end
    tick();
    #1;
    checks++;
    if (drained !== 1'b1) begin failures++; $display("FAIL dr_idle_step2 got drained=%b exp 1", drained); end
    drain_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_perf();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    u_up.rready = 1'b0;
    u_up.arvalid = 1'b1;
    repeat (14) tick();
    u_up.arvalid = 1'b0;
    #1;
    checks++;
    if (perf_rd_stall !== (PERF ? 32'd10 : 32'd0) || perf_wr_stall !== 32'd0) begin
      failures++; $display("FAIL perf_rd got %0d/%0d exp %0d/0", perf_rd_stall, perf_wr_stall, PERF ? 10 : 0);
    end
    u_dn.rvalid = 1'b1; u_dn.rlast = 1'b1; u_up.rready = 1'b1;
    repeat (4) tick();
    u_dn.rvalid = 1'b0; u_dn.rlast = 1'b0;
  endtask

  task automatic test_underflow();
    u_dn.bvalid = 1'b1; u_up.bready = 1'b1;
    tick();
    u_dn.bvalid = 1'b0;
    #1;
    checks++;
    if ({err_underflow, wr_outstanding} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL uf_set got uf=%b wr=%0d exp 1/0", err_underflow, wr_outstanding);
    end
    repeat (5) tick();
    checks++;
    if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got %b exp 1", err_underflow); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      u_up.arvalid = 1'($urandom_range(0, 1));
      u_up.araddr  = $urandom;
      u_up.awvalid = ($urandom_range(0, 2) == 0);
      u_up.awaddr  = $urandom;
      u_up.wvalid  = 1'($urandom_range(0, 1));
      u_up.wlast   = 1'($urandom_range(0, 1));
      u_up.wdata   = {$urandom, $urandom};
      u_up.rready  = 1'($urandom_range(0, 1));
      u_up.bready  = 1'($urandom_range(0, 1));
      u_dn.arready = ($urandom_range(0, 3) != 0);
      u_dn.awready = ($urandom_range(0, 3) != 0);
      u_dn.wready  = ($urandom_range(0, 3) != 0);
      u_dn.rvalid  = ($urandom_range(0, 2) == 0);
      u_dn.rlast   = 1'($urandom_range(0, 1));
      u_dn.rdata   = {$urandom, $urandom};
      u_dn.bvalid  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
      #1;
      checks++;
      if ({u_dn.arvalid, u_up.arready, u_dn.awvalid, u_up.awready, u_dn.wvalid, u_up.wready} !==
          {u_up.arvalid & m_ar_ok, u_dn.arready & m_ar_ok, u_up.awvalid & m_aw_ok,
           u_dn.awready & m_aw_ok, u_up.wvalid & m_w_ok, u_dn.wready & m_w_ok}) begin
        failures++;
        $display("FAIL rnd_gating cyc=%0d got %b exp %b", c,
                 {u_dn.arvalid, u_up.arready, u_dn.awvalid, u_up.awready, u_dn.wvalid, u_up.wready},
                 {u_up.arvalid & m_ar_ok, u_dn.arready & m_ar_ok, u_up.awvalid & m_aw_ok,
                  u_dn.awready & m_aw_ok, u_up.wvalid & m_w_ok, u_dn.wready & m_w_ok});
      end
      checks++;
      if (rd_outstanding !== m_rd[CW-1:0] || wr_outstanding !== m_wr[CW-1:0]) begin
        failures++; $display("FAIL rnd_counts cyc=%0d got %0d/%0d exp %0d/%0d", c, rd_outstanding, wr_outstanding, m_rd, m_wr);
      end
      checks++;
      if ({drained, err_underflow} !== {(m_mode == 2), m_uf}) begin
        failures++; $display("FAIL rnd_flags cyc=%0d got %b%b exp %b%b", c, drained, err_underflow, (m_mode == 2), m_uf);
      end
      checks++;
      if (perf_rd_stall !== m_prs || perf_wr_stall !== m_pws) begin
        failures++; $display("FAIL rnd_perf cyc=%0d got %0d/%0d exp %0d/%0d", c, perf_rd_stall, perf_wr_stall, m_prs, m_pws);
      end
      checks++;
      if ({u_dn.araddr, u_dn.awaddr, u_dn.wdata, u_up.rdata, u_up.rvalid, u_up.bvalid, u_dn.rready} !==
          {u_up.araddr, u_up.awaddr, u_up.wdata, u_dn.rdata, u_dn.rvalid, u_dn.bvalid, u_up.rready}) begin
        failures++; $display("FAIL rnd_passthru cyc=%0d araddr got %h exp %h", c, u_dn.araddr, u_up.araddr);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_read_limit();
    test_write_order();
    test_simultaneous();
    test_drain();
    test_perf();
    test_underflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
